// File: rtl/nerv_dmem_wb_bridge_pkg.sv
// Shared types and constants for the NERV data-port to second-memory-bus bridge.
package nerv_bridge_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [XLEN-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bridge_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/nerv_dmem_wb_bridge_if.sv
// Second-memory bus between the bridge (master) and the controller (slave).
interface nerv_dmem_wb_bridge_if;
  import nerv_bridge_pkg::*;

  logic              data_mem_cyc;
  logic              data_mem_stb;
  logic              data_mem_we;
  logic [STRB_W-1:0] data_mem_wstrb;
  logic [XLEN-1:0]   data_mem_addr;
  logic [XLEN-1:0]   data_mem_data_out;
  logic [XLEN-1:0]   data_mem_data_in;
  logic              data_mem_ack;

  modport master (
    output data_mem_cyc, data_mem_stb, data_mem_we, data_mem_wstrb,
           data_mem_addr, data_mem_data_out,
    input  data_mem_data_in, data_mem_ack
  );

  modport slave (
    input  data_mem_cyc, data_mem_stb, data_mem_we, data_mem_wstrb,
           data_mem_addr, data_mem_data_out,
    output data_mem_data_in, data_mem_ack
  );

endinterface

// File: rtl/nerv_dmem_wb_bridge.sv
// Stalls the NERV core on each data request, runs one bus transfer per request,
// and holds read data (or ERR_DATA on timeout) for the core's writeback cycle.
module nerv_dmem_wb_bridge
  import nerv_bridge_pkg::*;
#(
  parameter int unsigned     TIMEOUT_CYCLES = 256,
  parameter logic [XLEN-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk_core,
  input  logic              rst_core,
  input  logic              dmem_valid,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [STRB_W-1:0] dmem_wstrb,
  input  logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN-1:0]   dmem_rdata,
  output logic              stall,
  output logic              bus_err,
  nerv_dmem_wb_bridge_if.master bus
);

  localparam int unsigned TIMER_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TIMER_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  bridge_state_t      state;
  logic [TIMER_W-1:0] timer;
  logic               timeout_c;

  assign timeout_c = TIMEOUT_EN && (timer == TIMER_W'(TIMER_LAST));

  // Stall must cover the request cycle itself, before the bus is even strobed.
  assign stall = !rst_core && (((state == IDLE) && dmem_valid) || (state == REQ));

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state                 <= IDLE;
      timer                 <= '0;
      bus.data_mem_cyc      <= 1'b0;
      bus.data_mem_stb      <= 1'b0;
      bus.data_mem_we       <= 1'b0;
      bus.data_mem_wstrb    <= '0;
      bus.data_mem_addr     <= '0;
      bus.data_mem_data_out <= '0;
      dmem_rdata            <= '0;
      bus_err               <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dmem_valid) begin
            bus.data_mem_addr     <= word_align(dmem_addr);
            bus.data_mem_wstrb    <= dmem_wstrb;
            bus.data_mem_data_out <= dmem_wdata;
            bus.data_mem_we       <= |dmem_wstrb;
            bus.data_mem_cyc      <= 1'b1;
            bus.data_mem_stb      <= 1'b1;
            timer                 <= '0;
            state                 <= REQ;
          end
        end
        REQ: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (bus.data_mem_ack) begin
            if (!bus.data_mem_we) dmem_rdata <= bus.data_mem_data_in;
            bus.data_mem_cyc <= 1'b0;
            bus.data_mem_stb <= 1'b0;
            bus.data_mem_we  <= 1'b0;
            state            <= DONE;
          end else if (timeout_c) begin
            if (!bus.data_mem_we) dmem_rdata <= ERR_DATA;
            bus.data_mem_cyc <= 1'b0;
            bus.data_mem_stb <= 1'b0;
            bus.data_mem_we  <= 1'b0;
            bus_err          <= 1'b1;
            state            <= DONE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        DONE: begin
          // Core retires the still-presented request here; never re-issue it.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nerv_dmem_wb_bridge.sv
// Directed bench for nerv_dmem_wb_bridge: a transaction-level model checked every
// cycle on two instances (default timeout and a 4-cycle timeout), plus literal checks.
module tb_nerv_dmem_wb_bridge;

  logic        clk;
  logic        rst;
  logic        valid;
  bit          sel;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ack [2];
  logic [31:0] din [2];

  logic        valid_a, valid_b;
  logic [31:0] rdata_a, rdata_b;
  logic        stall_a, stall_b, err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  nerv_dmem_wb_bridge_if bus_a ();
  nerv_dmem_wb_bridge_if bus_b ();

  assign valid_a = valid && !sel;
  assign valid_b = valid && sel;
  assign bus_a.data_mem_ack     = ack[0];
  assign bus_a.data_mem_data_in = din[0];
  assign bus_b.data_mem_ack     = ack[1];
  assign bus_b.data_mem_data_in = din[1];

  nerv_dmem_wb_bridge #(.TIMEOUT_CYCLES(256), .ERR_DATA(32'hDEAD_BEEF)) dut_a (
    .clk_core(clk), .rst_core(rst), .dmem_valid(valid_a), .dmem_addr(addr),
    .dmem_wstrb(wstrb), .dmem_wdata(wdata), .dmem_rdata(rdata_a),
    .stall(stall_a), .bus_err(err_a), .bus(bus_a.master)
  );

  nerv_dmem_wb_bridge #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEAD_BEEF)) dut_b (
    .clk_core(clk), .rst_core(rst), .dmem_valid(valid_b), .dmem_addr(addr),
    .dmem_wstrb(wstrb), .dmem_wdata(wdata), .dmem_rdata(rdata_b),
    .stall(stall_b), .bus_err(err_b), .bus(bus_b.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected summary before it");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding bus transfer per DUT.
  bit          m_busy [2];
  bit          m_retire [2];
  int unsigned m_cnt [2];
  int unsigned m_to [2] = '{256, 4};
  logic        m_cyc [2];
  logic        m_we [2];
  logic [3:0]  m_wstrb [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_dout [2];
  logic [31:0] m_rdata [2];
  logic        m_err [2];
  bit          started = 1'b0;
  int          n_xfer [2] = '{0, 0};

  function automatic bit vld(input int d);
    return valid && ((d == 0) ? !sel : sel);
  endfunction

  task automatic model_step(input int d);
    logic [31:0] a;
    if (rst) begin
      m_busy[d] = 1'b0; m_retire[d] = 1'b0; m_cnt[d] = 0;
      m_cyc[d] = 1'b0; m_we[d] = 1'b0; m_wstrb[d] = 4'h0;
      m_addr[d] = 32'h0; m_dout[d] = 32'h0; m_rdata[d] = 32'h0; m_err[d] = 1'b0;
      started = 1'b1;
    end else begin
      m_err[d] = 1'b0;
      if (m_retire[d]) begin
        m_retire[d] = 1'b0;
      end else if (m_busy[d]) begin
        if (ack[d] || (m_to[d] != 0 && m_cnt[d] + 1 == m_to[d])) begin
          if (!m_we[d]) m_rdata[d] = ack[d] ? din[d] : 32'hDEAD_BEEF;
          m_err[d]    = !ack[d];
          m_cyc[d]    = 1'b0;
          m_we[d]     = 1'b0;
          m_busy[d]   = 1'b0;
          m_retire[d] = 1'b1;
        end else begin
          m_cnt[d]++;
        end
      end else if (vld(d)) begin
        a = addr;
        m_busy[d]  = 1'b1;
        m_cnt[d]   = 0;
        m_cyc[d]   = 1'b1;
        m_we[d]    = (wstrb != 4'h0);
        m_wstrb[d] = wstrb;
        m_addr[d]  = {a[31:2], 2'b00};
        m_dout[d]  = wdata;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp_dut(input int d, input logic st, input logic cy, input logic sb,
                         input logic w, input logic [3:0] ws, input logic [31:0] ad,
                         input logic [31:0] dout, input logic [31:0] rd, input logic er);
    logic exp_stall;
    exp_stall = !rst && (m_busy[d] || (!m_retire[d] && vld(d)));
    check($sformatf("stall_%0d", d), 32'(st), 32'(exp_stall));
    check($sformatf("cyc_%0d", d), 32'(cy), 32'(m_cyc[d]));
    check($sformatf("stb_%0d", d), 32'(sb), 32'(m_cyc[d]));
    check($sformatf("we_%0d", d), 32'(w), 32'(m_we[d]));
    check($sformatf("wstrb_%0d", d), 32'(ws), 32'(m_wstrb[d]));
    check($sformatf("addr_%0d", d), ad, m_addr[d]);
    check($sformatf("data_out_%0d", d), dout, m_dout[d]);
    check($sformatf("rdata_%0d", d), rd, m_rdata[d]);
    check($sformatf("bus_err_%0d", d), 32'(er), 32'(m_err[d]));
  endtask

  // Per-cycle compare on the falling edge, plus bus-transfer counting.
  initial begin
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    forever begin
      @(negedge clk);
      if (started) begin
        cmp_dut(0, stall_a, bus_a.data_mem_cyc, bus_a.data_mem_stb, bus_a.data_mem_we,
                bus_a.data_mem_wstrb, bus_a.data_mem_addr, bus_a.data_mem_data_out, rdata_a, err_a);
        cmp_dut(1, stall_b, bus_b.data_mem_cyc, bus_b.data_mem_stb, bus_b.data_mem_we,
                bus_b.data_mem_wstrb, bus_b.data_mem_addr, bus_b.data_mem_data_out, rdata_b, err_b);
        if (bus_a.data_mem_cyc === 1'b1 && !prev_a) n_xfer[0]++;
        if (bus_b.data_mem_cyc === 1'b1 && !prev_b) n_xfer[1]++;
        prev_a = (bus_a.data_mem_cyc === 1'b1);
        prev_b = (bus_b.data_mem_cyc === 1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Present one request; returns in the cycle after completion with the stall-cycle count.
  task automatic xfer(input int d, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] w, input int k, input bit give_ack,
                      input logic [31:0] dv, output int stalls);
    logic sd;
    tick();
    sel = (d != 0); valid = 1'b1; addr = a; wstrb = s; wdata = w;
    mid();
    sd = (d != 0) ? stall_b : stall_a;
    stalls = int'(sd);
    for (int c = 0; c < 300; c++) begin
      tick();
      ack[d] = give_ack && (c == k);
      din[d] = dv;
      mid();
      sd = (d != 0) ? stall_b : stall_a;
      if (!sd) return;
      stalls++;
    end
    check($sformatf("xfer_bound_%0d", d), 32'(sd), 32'd0);
  endtask

  task automatic idle_cycle();
    tick();
    valid = 1'b0;
    mid();
  endtask

  initial begin
    int st, st2, n0;
    rst = 1'b1; valid = 1'b0; sel = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    ack[0] = 1'b0; ack[1] = 1'b0; din[0] = '0; din[1] = '0;
    tick(); tick();
    mid();
    check("reset_cyc_a", 32'(bus_a.data_mem_cyc), 32'd0);
    check("reset_rdata_a", rdata_a, 32'd0);
    check("reset_stall_b", 32'(stall_b), 32'd0);
    check("reset_err_b", 32'(err_b), 32'd0);
    tick(); rst = 1'b0; mid();

    // Read, ack in the first REQ cycle
    xfer(0, 32'h0000_1006, 4'b0000, 32'h0, 0, 1'b1, 32'h1234_5678, st);
    check("read_stall_cycles", 32'(st), 32'd2);
    check("read_rdata", rdata_a, 32'h1234_5678);
    check("read_addr", bus_a.data_mem_addr, 32'h0000_1004);
    idle_cycle();

    // Write, ack after 5 cycles: 6 REQ cycles, rdata untouched
    xfer(0, 32'h0000_2002, 4'b0011, 32'hAABB_CCDD, 5, 1'b1, 32'hFFFF_FFFF, st);
    check("write_stall_cycles", 32'(st), 32'd7);
    check("write_rdata_kept", rdata_a, 32'h1234_5678);
    idle_cycle();

    // Timeout of 4 on dut_b
    xfer(1, 32'h0000_3008, 4'b0000, 32'h0, 0, 1'b0, 32'h0, st);
    check("timeout_stall_cycles", 32'(st), 32'd5);
    check("timeout_bus_err", 32'(err_b), 32'd1);
    check("timeout_rdata", rdata_b, 32'hDEAD_BEEF);
    check("timeout_cyc", 32'(bus_b.data_mem_cyc), 32'd0);
    idle_cycle();
    check("timeout_err_pulse", 32'(err_b), 32'd0);

    // Ack on the timeout cycle wins
    xfer(1, 32'h0000_300C, 4'b0000, 32'h0, 3, 1'b1, 32'hCAFE_F00D, st);
    check("coincide_stall_cycles", 32'(st), 32'd5);
    check("coincide_bus_err", 32'(err_b), 32'd0);
    check("coincide_rdata", rdata_b, 32'hCAFE_F00D);
    idle_cycle();

    // Timed-out write keeps read data
    xfer(1, 32'h0000_3010, 4'b1111, 32'h1122_3344, 0, 1'b0, 32'h0, st);
    check("wr_timeout_err", 32'(err_b), 32'd1);
    check("wr_timeout_rdata", rdata_b, 32'hCAFE_F00D);
    idle_cycle();

    // Back-to-back with valid held through DONE
    n0 = n_xfer[0];
    xfer(0, 32'h0000_4000, 4'b0000, 32'h0, 0, 1'b1, 32'h5555_AAAA, st);
    xfer(0, 32'h0000_4004, 4'b1111, 32'h0102_0304, 2, 1'b1, 32'h0, st2);
    check("b2b_transfers", 32'(n_xfer[0] - n0), 32'd2);
    check("b2b_first_stall", 32'(st), 32'd2);
    check("b2b_second_stall", 32'(st2), 32'd4);
    check("b2b_rdata", rdata_a, 32'h5555_AAAA);
    idle_cycle();

    // Default 256-cycle timeout on dut_a
    xfer(0, 32'h0000_5000, 4'b0000, 32'h0, 0, 1'b0, 32'h0, st);
    check("long_timeout_stall", 32'(st), 32'd257);
    check("long_timeout_err", 32'(err_a), 32'd1);
    check("long_timeout_rdata", rdata_a, 32'hDEAD_BEEF);
    idle_cycle();

    // Reset in the middle of REQ, then a late ack
    tick(); sel = 1'b0; valid = 1'b1; addr = 32'h0000_6000; wstrb = 4'b0000;
    mid();
    tick(); mid();
    tick(); rst = 1'b1;
    mid();
    check("rst_req_stall_forced", 32'(stall_a), 32'd0);
    tick(); rst = 1'b0; valid = 1'b0; ack[0] = 1'b1; din[0] = 32'hFFFF_0000;
    mid();
    check("rst_req_cyc", 32'(bus_a.data_mem_cyc), 32'd0);
    check("rst_req_stb", 32'(bus_a.data_mem_stb), 32'd0);
    check("rst_req_stall", 32'(stall_a), 32'd0);
    tick(); ack[0] = 1'b0;
    mid();
    check("late_ack_rdata", rdata_a, 32'h0000_0000);
    check("late_ack_cyc", 32'(bus_a.data_mem_cyc), 32'd0);

    // Fresh request after reset starts from IDLE
    xfer(0, 32'h0000_7003, 4'b0000, 32'h0, 0, 1'b1, 32'h7777_7777, st);
    check("post_rst_stall", 32'(st), 32'd2);
    check("post_rst_rdata", rdata_a, 32'h7777_7777);
    idle_cycle();
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
